// File: rtl/rv32_instr_encoder.sv
// rtl/rv32_instr_encoder.sv - packs field-level RV32I requests into 32-bit words for the imem fill path
//
// Purpose: checks and encodes one instruction request per cycle. The request
// is held in a single output register until the sink accepts it. Each
// delivered word carries a write address that steps by ADDR_STEP.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   clear          synchronous flush: empties the pipe, reloads the address, zeroes counters and err
//   in_valid       request valid; in_ready = !out_valid || out_ready
//   in_fmt         0=R 1=I 2=S 3=B 4=U 5=J (6,7 illegal)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm   instruction fields
//   out_valid/out_ready/out_word/out_addr   encoded word and its byte address
//   word_count     delivered words, saturating
//   err, err_count sticky reject flag and saturating reject count
module rv32_instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_STEP = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [31:0] out_addr,
   output logic [15:0] word_count,
   output logic        err,
   output logic [7:0]  err_count
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic [31:0] x;
   logic [31:0] enc_word;
   logic        fmt_bad;
   logic        imm_bad;
   logic        reject;
   logic        accept;
   logic        handshake;

   assign x         = in_imm;
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;

   // A signed N-bit value fits when every bit above N-1 repeats the sign bit.
   always_comb begin
      enc_word = 32'h0;
      fmt_bad  = 1'b0;
      imm_bad  = 1'b0;
      case (in_fmt)
         FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I: begin
            enc_word = {x[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            imm_bad  = (x[31:11] != {21{x[11]}});
         end
         FMT_S: begin
            enc_word = {x[11:5], in_rs2, in_rs1, in_funct3, x[4:0], in_opcode};
            imm_bad  = (x[31:11] != {21{x[11]}});
         end
         FMT_B: begin
            enc_word = {x[12], x[10:5], in_rs2, in_rs1, in_funct3, x[4:1], x[11], in_opcode};
            imm_bad  = (x[31:12] != {20{x[12]}}) || x[0];
         end
         FMT_U: begin
            enc_word = {x[31:12], in_rd, in_opcode};
            imm_bad  = (x[11:0] != 12'h000);
         end
         FMT_J: begin
            enc_word = {x[20], x[10:1], x[11], x[19:12], in_rd, in_opcode};
            imm_bad  = (x[31:20] != {12{x[20]}}) || x[0];
         end
         default: fmt_bad = 1'b1;
      endcase
   end

   assign reject = fmt_bad || imm_bad || (in_opcode[1:0] != 2'b11);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_word   <= 32'h0;
         out_addr   <= BASE_ADDR;
         word_count <= 16'h0;
         err        <= 1'b0;
         err_count  <= 8'h0;
      end else if (clear) begin
         // Pending word and any same-cycle request are discarded uncounted.
         out_valid  <= 1'b0;
         out_addr   <= BASE_ADDR;
         word_count <= 16'h0;
         err        <= 1'b0;
         err_count  <= 8'h0;
      end else begin
         // out_addr always names the slot for the word currently (or next) in the register.
         if (handshake) begin
            out_valid <= 1'b0;
            out_addr  <= out_addr + ADDR_STEP;
            if (word_count != 16'hFFFF) begin
               word_count <= word_count + 16'd1;
            end
         end
         if (accept) begin
            if (reject) begin
               err <= 1'b1;
               if (err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
               end
            end else begin
               out_valid <= 1'b1;
               out_word  <= enc_word;
            end
         end
      end
   end

endmodule
